// File: rtl/div_seq_ctrl_pkg.sv
// Shared constants and types for the iterative DIV/DIVU sequencer.
// Optional early-out path is enabled with DIV_SEQ_EARLY_OUT_EN.
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } div_sign_t;

endpackage

// File: rtl/div_seq_ctrl_div_iter_step.sv
// One radix-2 restoring divide iteration, purely combinational.
// Takes the running {rem, quo} pair and produces the next pair.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           borrow;

    // rem < divisor always holds, so the MSB of diff is a clean borrow
    assign trial    = {rem, quo[WIDTH-1]};
    assign diff     = trial - {1'b0, divisor};
    assign borrow   = diff[WIDTH];
    assign rem_next = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative DIV/DIVU datapath in execute.
// DIV_SEQ_EARLY_OUT_EN enables a 1-cycle path when |src1| < |src2|.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    input  logic             out_ready,
    output logic             div_stall,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    div_sign_t        sgn_q;
    logic             first_q;

    logic             st_idle;
    logic             st_busy;
    logic             st_done;
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic             launch;
    logic             div_zero;
    logic             early;
    logic             last;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    assign st_idle  = (state == DIV_IDLE);
    assign st_busy  = (state == DIV_BUSY);
    assign st_done  = (state == DIV_DONE);

    assign s1_neg   = is_signed & src1[WIDTH-1];
    assign s2_neg   = is_signed & src2[WIDTH-1];
    assign abs1     = s1_neg ? -src1 : src1;
    assign abs2     = s2_neg ? -src2 : src2;

    assign launch   = st_idle & start & ~cancel;
    assign div_zero = (src2 == '0);
    assign last     = st_busy & (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_SEQ_EARLY_OUT_EN
    assign early    = (abs1 < abs2);
`else
    assign early    = 1'b0;
`endif

    div_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_next(rem_nx),
        .quo_next(quo_nx)
    );

    // Sign fix-up is applied to the final iteration output on the way into DONE
    assign quo_fin   = sgn_q.neg_q ? -quo_nx : quo_nx;
    assign rem_fin   = sgn_q.neg_r ? -rem_nx : rem_nx;

    assign div_stall = launch | st_busy;
    assign busy      = ~st_idle;
    assign done      = st_done;
    assign hilo_we   = st_done & first_q & ~cancel;
    assign quotient  = quo_r;
    assign remainder = rem_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            sgn_q   <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= 1'b0;
            unique case (state)
                DIV_IDLE: begin
                    if (launch) begin
                        if (div_zero) begin
                            state   <= DIV_DONE;
                            quo_r   <= '1;
                            rem_r   <= src1;
                            first_q <= 1'b1;
                        end else if (early) begin
                            state   <= DIV_DONE;
                            quo_r   <= '0;
                            rem_r   <= src1;
                            first_q <= 1'b1;
                        end else begin
                            state       <= DIV_BUSY;
                            cnt         <= '0;
                            rem_q       <= '0;
                            quo_q       <= abs1;
                            dvs_q       <= abs2;
                            sgn_q.neg_q <= s1_neg ^ s2_neg;
                            sgn_q.neg_r <= s1_neg;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + CNT_W'(1);
                        if (last) begin
                            state   <= DIV_DONE;
                            quo_r   <= quo_fin;
                            rem_r   <= rem_fin;
                            first_q <= 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    if (cancel | out_ready) begin
                        state <= DIV_IDLE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, corner sequences
// and randomized operands against an arithmetic reference model.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        out_ready;
    logic        div_stall;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int tests = 0;
    int fails = 0;

    div_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .src1     (src1),
        .src2     (src2),
        .cancel   (cancel),
        .out_ready(out_ready),
        .div_stall(div_stall),
        .busy     (busy),
        .done     (done),
        .hilo_we  (hilo_we),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        if (s && v[31]) return -v;
        return v;
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           input logic s, output logic [31:0] q,
                           output logic [31:0] r);
        int sa;
        int sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            sa = int'(a);
            sb = int'(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        if (b == 0) return 1;
`ifdef DIV_SEQ_EARLY_OUT_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq,
                          input logic [31:0] er, input string nm);
        int cyc;
        int stalls;
        int lat;
        lat = ref_lat(a, b, s);
        @(negedge clk);
        src1 = a;
        src2 = b;
        is_signed = s;
        start = 1'b1;
        cancel = 1'b0;
        out_ready = 1'b1;
        #1;
        stalls = int'(div_stall);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!done) stalls += int'(div_stall);
        end
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " stalls"}, 32'(stalls), 32'(lat));
        chk({nm, " quo"}, quotient, eq);
        chk({nm, " rem"}, remainder, er);
        chk({nm, " we"}, {31'd0, hilo_we}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk({nm, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          we_cnt;

        vecs.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0});
        vecs.push_back('{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5});
        vecs.push_back('{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB});
        vecs.push_back('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0});
        vecs.push_back('{32'd3, 32'd10, 1'b0, 32'd0, 32'd3});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1});
        vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1});

        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        src1 = '0;
        src2 = '0;
        cancel = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outs", {28'd0, div_stall, busy, done, hilo_we}, 32'd0);
        chk("reset quo", quotient, 32'd0);
        chk("reset rem", remainder, 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r,
                   $sformatf("vec%0d", i));

        // cancel in the 10th BUSY cycle, results must keep previous values
        @(negedge clk);
        src1 = 32'd1000;
        src2 = 32'd3;
        is_signed = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        we_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            we_cnt += int'(hilo_we);
        end
        cancel = 1'b1;
        start = 1'b0;
        @(negedge clk);
        we_cnt += int'(hilo_we);
        chk("cancel busy", {30'd0, busy, done}, 32'd0);
        chk("cancel we", 32'(we_cnt), 32'd0);
        chk("cancel quo held", quotient, 32'h7FFF_FFFC);
        cancel = 1'b0;
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "after cancel");

        // hold DONE with out_ready low and start still high
        @(negedge clk);
        src1 = 32'd100;
        src2 = 32'd7;
        start = 1'b1;
        out_ready = 1'b0;
        we_cnt = 0;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        we_cnt += int'(hilo_we);
        repeat (3) begin
            @(negedge clk);
            we_cnt += int'(hilo_we);
            chk("hold done", {31'd0, done}, 32'd1);
            chk("hold quo", quotient, 32'd14);
        end
        chk("hold we once", 32'(we_cnt), 32'd1);
        out_ready = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("hold exit", {30'd0, busy, done}, 32'd0);

        // cancel on the first DONE cycle suppresses the write strobe
        @(negedge clk);
        src1 = 32'd50;
        src2 = 32'd6;
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        cancel = 1'b1;
        start = 1'b0;
        #1;
        chk("done cancel we", {31'd0, hilo_we}, 32'd0);
        @(negedge clk);
        chk("done cancel idle", {30'd0, busy, done}, 32'd0);
        cancel = 1'b0;
        out_ready = 1'b1;

        // asynchronous reset in the 5th BUSY cycle
        @(negedge clk);
        src1 = 32'd77;
        src2 = 32'd5;
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst mid outs", {28'd0, div_stall, busy, done, hilo_we}, 32'd0);
        chk("rst mid quo", quotient, 32'd0);
        chk("rst mid rem", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = 32'(0 - $urandom_range(1, 20));
                default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom);
            ref_div(a, b, s, eq, er);
            run_op(a, b, s, eq, er, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
